// File: rtl/cw_delta_reader_if.sv
// +--------------------------------------------------------------------------+
// | cw_delta_reader_if : start/bit-stream/result bundle of the delta reader  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cw_delta_reader_if #(
  parameter int DW = 20,
  parameter int UW = 5
);
  logic          start;
  logic [DW-1:0] d;
  logic [UW-1:0] u;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [DW-1:0] delta;
  logic          is_full;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    output start, d, u, bit_in, bit_valid, out_ready,
    input  bit_ready, delta, is_full, out_valid, busy
  );

  modport slave (
    input  start, d, u, bit_in, bit_valid, out_ready,
    output bit_ready, delta, is_full, out_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/cw_delta_reader.sv
// +--------------------------------------------------------------------------+
// | cw_delta_reader : decodes one run-length symbol (flag + u bits) into     |
// | delta for the constant-weight encoder.                 Rev 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module cw_delta_reader #(
  parameter int DW = 20,
  parameter int UW = 5
) (
  input  logic                clk,
  input  logic                rst,
  cw_delta_reader_if.slave    bus
);
  localparam int c_CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLAG = 2'd1,
    READ = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_d;
  logic [c_CW-1:0] r_u;
  logic [DW-1:0]   r_acc;
  logic [c_CW-1:0] r_cnt;
  logic [DW-1:0]   r_delta;
  logic            r_is_full;
  logic            r_out_valid;
  logic            r_bit_ready;
  logic            r_busy;

  logic [31:0]     w_u_ext;
  logic [c_CW-1:0] w_u_clamp;
  logic [DW-1:0]   w_shift;
  logic            w_accept;

  // u beyond the data width would shift out meaningful bits, so cap it at DW
  assign w_u_ext   = 32'(bus.u);
  assign w_u_clamp = (w_u_ext > 32'(DW)) ? c_CW'(DW) : c_CW'(bus.u);
  assign w_shift   = {r_acc[DW-2:0], bus.bit_in};
  assign w_accept  = bus.bit_valid && r_bit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_d         <= '0;
      r_u         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_delta     <= '0;
      r_is_full   <= 1'b0;
      r_out_valid <= 1'b0;
      r_bit_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_d         <= bus.d;
            r_u         <= w_u_clamp;
            r_state     <= FLAG;
            r_bit_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        FLAG: begin
          if (w_accept) begin
            if (bus.bit_in) begin
              r_delta     <= r_d;
              r_is_full   <= 1'b1;
              r_state     <= EMIT;
              r_bit_ready <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_acc     <= '0;
              r_cnt     <= r_u;
              r_is_full <= 1'b0;
              if (r_u == '0) begin
                r_delta     <= '0;
                r_state     <= EMIT;
                r_bit_ready <= 1'b0;
                r_out_valid <= 1'b1;
              end else begin
                r_state <= READ;
              end
            end
          end
        end
        READ: begin
          if (w_accept) begin
            r_acc <= w_shift;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == c_CW'(1)) begin
              r_delta     <= w_shift;
              r_state     <= EMIT;
              r_bit_ready <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          // result stays parked until the consumer takes it
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_bit_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_ready = r_bit_ready;
  assign bus.delta     = r_delta;
  assign bus.is_full   = r_is_full;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_cw_delta_reader.sv
// +--------------------------------------------------------------------------+
// | tb_cw_delta_reader : directed and random symbols against a bit-queue     |
// | reference model.                                       Rev 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cw_delta_reader;
  localparam int c_DW = 20;
  localparam int c_UW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cw_delta_reader_if #(.DW(c_DW), .UW(c_UW)) bus ();

  cw_delta_reader #(.DW(c_DW), .UW(c_UW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stall: 0 none, 1 every other cycle, 2 random; latency is checked only without stalls
  task automatic do_symbol(input string tag, input logic [c_DW-1:0] dd, input logic [c_UW-1:0] uu,
                           input bit flag, input logic [c_DW-1:0] bits, input int stall,
                           input int bp, input bit mid_start);
    int        ub;
    int        nbits;
    int        cyc;
    bit        acc;
    bit        stl;
    int        expv;
    bit        q[$];

    ub    = (int'(uu) > c_DW) ? c_DW : int'(uu);
    expv  = 0;
    q.delete();
    q.push_back(flag);
    if (flag) begin
      expv  = int'(dd);
      nbits = 1;
    end else begin
      for (int i = ub - 1; i >= 0; i--) begin
        q.push_back(bits[i]);
        expv = expv * 2 + int'(bits[i]);
      end
      nbits = 1 + ub;
    end

    @(negedge clk);
    bus.start = 1'b1; bus.d = dd; bus.u = uu;
    @(negedge clk);
    bus.start = 1'b0;
    bus.d = $urandom; bus.u = c_UW'($urandom);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    cyc = 1;
    while (!bus.out_valid && cyc < 400) begin
      stl = (stall == 1) ? (cyc % 2 == 0) : ((stall == 2) ? ($urandom_range(0, 1) == 0) : 1'b0);
      bus.bit_valid = (q.size() > 0) && !stl;
      bus.bit_in    = (q.size() > 0) ? q[0] : 1'b0;
      bus.start     = mid_start && (cyc == 2);
      if (mid_start && cyc == 2) begin
        bus.d = c_DW'(4); bus.u = c_UW'(2);
      end
      acc = bus.bit_valid && bus.bit_ready;
      @(negedge clk);
      cyc++;
      if (acc) void'(q.pop_front());
    end
    bus.bit_valid = 1'b0;
    bus.start     = 1'b0;
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    if (!bus.out_valid) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    if (stall == 0) chk({tag, "_latency"}, 32'(cyc), 32'(nbits + 1));
    chk({tag, "_bits_left"}, 32'(q.size()), 32'd0);
    chk({tag, "_delta"}, 32'(bus.delta), 32'(expv));
    chk({tag, "_is_full"}, 32'(bus.is_full), 32'(flag));
    chk({tag, "_bit_ready_emit"}, 32'(bus.bit_ready), 32'd0);
    for (int k = 0; k < bp; k++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = $urandom_range(0, 1);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_delta"}, 32'(bus.delta), 32'(expv));
    end
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
    if (mid_start) begin
      repeat (3) @(negedge clk);
      chk({tag, "_no_second"}, 32'(bus.busy | bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.d = '0; bus.u = '0;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_delta", 32'(bus.delta), 32'd0);
    chk("rst_is_full", 32'(bus.is_full), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // reset in READ after flag 0 and two of four payload bits
    @(negedge clk);
    bus.start = 1'b1; bus.d = c_DW'(16); bus.u = c_UW'(4);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bit_valid = 1'b1; bus.bit_in = 1'b0;
    @(negedge clk); bus.bit_in = 1'b1;
    @(negedge clk); bus.bit_in = 1'b0;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_bit_ready", 32'(bus.bit_ready), 32'd0);
    do_symbol("after_rst", c_DW'(4), c_UW'(2), 1'b0, c_DW'(3), 0, 0, 1'b0);

    do_symbol("full", c_DW'(16), c_UW'(4), 1'b1, c_DW'(0), 0, 0, 1'b0);
    do_symbol("short", c_DW'(16), c_UW'(4), 1'b0, c_DW'(11), 0, 0, 1'b0);
    do_symbol("stall_bp", c_DW'(524288), c_UW'(19), 1'b0, c_DW'(20'h7FFFF), 1, 3, 1'b0);
    do_symbol("ign_start", c_DW'(16), c_UW'(4), 1'b0, c_DW'(9), 0, 0, 1'b1);
    do_symbol("clamp31", c_DW'(20'hABCDE), c_UW'(31), 1'b0, c_DW'(20'hFEDCB), 0, 0, 1'b0);
    do_symbol("u0_short", c_DW'(1), c_UW'(0), 1'b0, c_DW'(20'hFFFFF), 0, 0, 1'b0);
    do_symbol("odd_d_full", c_DW'(12345), c_UW'(3), 1'b1, c_DW'(0), 2, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_symbol("rand", c_DW'($urandom), c_UW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                c_DW'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
